// File: rtl/gpio_pkg.sv
// Shared GPIO constants and the small enums used by the debounce block.
package gpio_pkg;

  localparam int GPIO_WIDTH     = 8;
  localparam int GPIO_CNT_WIDTH = 4;

  // Tick qualifier: wait for the synchronizer to fill, then for a real low level.
  typedef enum logic [1:0] {
    TS_FILL0    = 2'd0,
    TS_FILL1    = 2'd1,
    TS_WAIT_LOW = 2'd2,
    TS_RUN      = 2'd3
  } tick_state_t;

  typedef enum logic [1:0] {
    PA_HOLD   = 2'd0,
    PA_CLEAR  = 2'd1,
    PA_COUNT  = 2'd2,
    PA_ACCEPT = 2'd3
  } pin_action_t;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for a vector of independent asynchronous levels.
module gpio_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/gpio_debounce.sv
// Per-pin debouncer: a pin change is accepted after thr consecutive differing
// samples taken on rising edges of the synchronized divided clock.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int               WIDTH     = GPIO_WIDTH,
  parameter int               CNT_WIDTH = GPIO_CNT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 div_clk,
  input  logic [WIDTH-1:0]     pins_in,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] stable_cycles,
  output logic [WIDTH-1:0]     pins_out,
  output logic [WIDTH-1:0]     rise,
  output logic [WIDTH-1:0]     fall,
  output logic                 changed
);

  localparam logic [CNT_WIDTH:0] ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0]   sync_pin;
  logic               sync_div;
  logic               div_q;
  logic               tick;
  logic [CNT_WIDTH:0] thr;
  tick_state_t        ts_q;
  tick_state_t        ts_d;

  gpio_sync #(.WIDTH(WIDTH)) u_pin_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pins_in),
    .q     (sync_pin)
  );

  gpio_sync #(.WIDTH(1)) u_div_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (div_clk),
    .q     (sync_div)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 1'b0;
      ts_q  <= TS_FILL0;
    end else begin
      div_q <= sync_div;
      ts_q  <= ts_d;
    end
  end

  // The synchronizer output is only meaningful after two edges; a div_clk that
  // is already high at release must be seen low before it may tick.
  always_comb begin
    ts_d = ts_q;
    case (ts_q)
      TS_FILL0:    ts_d = TS_FILL1;
      TS_FILL1:    ts_d = TS_WAIT_LOW;
      TS_WAIT_LOW: if (!sync_div) ts_d = TS_RUN;
      TS_RUN:      ts_d = TS_RUN;
      default:     ts_d = TS_FILL0;
    endcase
  end

  assign tick = (ts_q == TS_RUN) & sync_div & ~div_q;
  assign thr  = (stable_cycles == '0) ? ONE : {1'b0, stable_cycles};

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH:0]   count_inc;
    logic                 out_r;
    logic                 rise_r;
    logic                 fall_r;
    pin_action_t          action;

    // One bit wider than the counter so a lowered threshold cannot wrap.
    assign count_inc = {1'b0, count} + ONE;

    always_comb begin
      action = PA_HOLD;
      if (!en) begin
        action = PA_CLEAR;
      end else if (tick) begin
        if (sync_pin[i] == out_r)  action = PA_CLEAR;
        else if (count_inc >= thr) action = PA_ACCEPT;
        else                       action = PA_COUNT;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count  <= '0;
        out_r  <= RESET_VAL[i];
        rise_r <= 1'b0;
        fall_r <= 1'b0;
      end else begin
        rise_r <= 1'b0;
        fall_r <= 1'b0;
        case (action)
          PA_CLEAR: count <= '0;
          PA_COUNT: count <= count_inc[CNT_WIDTH-1:0];
          PA_ACCEPT: begin
            count  <= '0;
            out_r  <= sync_pin[i];
            rise_r <= sync_pin[i];
            fall_r <= ~sync_pin[i];
          end
          default: count <= count;
        endcase
      end
    end

    assign pins_out[i] = out_r;
    assign rise[i]     = rise_r;
    assign fall[i]     = fall_r;
  end

  assign changed = |(rise | fall);

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce: directed scenarios plus random stimulus, checked by a
// tick-level reference model feeding an expected-event queue.
module tb_gpio_debounce;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam logic [W-1:0] RV = 8'hA5;
  localparam int EW = 32 + 3 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          div_clk;
  logic          en;
  logic [W-1:0]  pins_in;
  logic [CW-1:0] stable_cycles;
  logic [W-1:0]  pins_out;
  logic [W-1:0]  rise;
  logic [W-1:0]  fall;
  logic          changed;

  int errors = 0;
  int checks = 0;

  // Clock / reset
  always #5 clk = ~clk;

  gpio_debounce #(.WIDTH(W), .CNT_WIDTH(CW), .RESET_VAL(RV)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .div_clk       (div_clk),
    .pins_in       (pins_in),
    .en            (en),
    .stable_cycles (stable_cycles),
    .pins_out      (pins_out),
    .rise          (rise),
    .fall          (fall),
    .changed       (changed)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per clk edge, the sample history of every input decides
  // whether this edge is a tick and what each pin's debouncer does with it.
  int            cyc = 0;
  int            k   = 0;
  logic [W-1:0]  pin_hist[$];
  logic          div_hist[$];
  logic [W-1:0]  ref_out = RV;
  int            ref_cnt[W];
  logic [EW-1:0] exp_q[$];

  always @(posedge clk) begin : ref_model
    logic         is_tick;
    logic         s;
    int           thr;
    logic [W-1:0] r;
    logic [W-1:0] f;
    cyc++;
    if (!rst_n) begin
      k = 0;
      pin_hist.delete();
      div_hist.delete();
      ref_out = RV;
      for (int i = 0; i < W; i++) ref_cnt[i] = 0;
    end else begin
      k++;
      pin_hist.push_back(pins_in);
      div_hist.push_back(div_clk);
      // Entry j-1 is the sample of edge j; inputs take two edges to be usable,
      // and a tick needs a low-then-high pair sampled entirely after release.
      is_tick = (k >= 4) && div_hist[k-3] && !div_hist[k-4];
      thr = (stable_cycles == 0) ? 1 : int'(stable_cycles);
      r = '0;
      f = '0;
      for (int i = 0; i < W; i++) begin
        if (!en) begin
          ref_cnt[i] = 0;
        end else if (is_tick) begin
          s = pin_hist[k-3][i];
          if (s == ref_out[i]) begin
            ref_cnt[i] = 0;
          end else if (ref_cnt[i] + 1 >= thr) begin
            ref_out[i] = s;
            ref_cnt[i] = 0;
            if (s) r[i] = 1'b1;
            else   f[i] = 1'b1;
          end else begin
            ref_cnt[i] = ref_cnt[i] + 1;
          end
        end
      end
      if ((r | f) != '0) exp_q.push_back({32'(cyc), ref_out, r, f});
    end
  end

  // Monitor: pops expectations whenever the DUT presents an edge event.
  int event_cnt    = 0;
  bit saw_all_rise = 1'b0;

  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event: cycle %0d expected out=%0h rise=%0h fall=%0h, no pulse seen",
               int'(e[EW-1 -: 32]), e[3*W-1 -: W], e[2*W-1 -: W], e[W-1:0]);
    end
    if (changed || rise != '0 || fall != '0) begin
      event_cnt++;
      if (rise == 8'hFF) saw_all_rise = 1'b1;
      if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
        e = exp_q.pop_front();
        check("event_out_rise_fall_changed", {pins_out, rise, fall, changed}, {e[3*W-1:0], 1'b1});
      end else begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: cycle %0d out=%0h rise=%0h fall=%0h changed=%0b, none expected",
                 cyc, pins_out, rise, fall, changed);
      end
    end
    check("pins_out", pins_out, ref_out);
  end

  // Driver tasks
  bit div_auto = 1'b1;
  int div_half = 2;
  int div_ctr  = 0;

  always @(negedge clk) begin
    if (div_auto) begin
      div_ctr++;
      if (div_ctr >= div_half) begin
        div_clk = ~div_clk;
        div_ctr = 0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after a falling clk edge; asserts reset mid-cycle.
  task automatic do_reset(input int n);
    #2 rst_n = 1'b0;
    #1 check("reset_async_pins_out", pins_out, RV);
    check("reset_async_no_pulse", {rise, fall, changed}, '0);
    cycles(n);
    rst_n = 1'b1;
  endtask

  initial begin : stimulus
    int n0;
    int idx;
    rst_n         = 1'b0;
    en            = 1'b1;
    stable_cycles = 4'd3;
    pins_in       = RV;
    div_clk       = 1'b0;
    cycles(3);
    check("reset_pins_out", pins_out, RV);
    check("reset_no_pulse", {rise, fall, changed}, '0);
    rst_n = 1'b1;
    cycles(30);

    // pin0 falls, then 0->1 held steady with thr=3
    pins_in = RV & ~8'h01;
    cycles(40);
    pins_in = RV;
    cycles(40);
    check("pin0_risen", pins_out[0], 1'b1);

    // pin2 single-tick glitch
    pins_in = RV & ~8'h04;
    cycles(40);
    n0 = event_cnt;
    pins_in[2] = 1'b1;
    cycles(4);
    pins_in[2] = 1'b0;
    cycles(40);
    check("glitch_no_event", event_cnt - n0, 0);
    check("glitch_pin2_low", pins_out[2], 1'b0);

    // thr=0 treated as 1, all pins together
    stable_cycles = 4'd0;
    pins_in = 8'h00;
    cycles(40);
    saw_all_rise = 1'b0;
    pins_in = 8'hFF;
    cycles(20);
    check("all_rise_same_cycle", saw_all_rise, 1'b1);

    // en=0 while pin5 changes
    stable_cycles = 4'd3;
    en = 1'b0;
    n0 = event_cnt;
    pins_in[5] = 1'b0;
    cycles(40);
    check("en_low_no_event", event_cnt - n0, 0);
    check("en_low_pin5_held", pins_out[5], 1'b1);
    en = 1'b1;
    cycles(20);
    check("en_high_pin5_updated", pins_out[5], 1'b0);

    // reset mid-count
    pins_in[6] = 1'b0;
    cycles(7);
    n0 = event_cnt;
    do_reset(3);
    cycles(8);
    check("reset_midcount_no_event", event_cnt - n0, 0);
    cycles(30);
    check("after_reset_recount", pins_out, pins_in);

    // div_clk high across reset release
    div_auto = 1'b0;
    div_clk  = 1'b1;
    stable_cycles = 4'd1;
    do_reset(3);
    pins_in = 8'h5A;
    n0 = event_cnt;
    cycles(20);
    check("div_high_no_tick", event_cnt - n0, 0);
    check("div_high_pins_held", pins_out, RV);
    div_clk = 1'b0;
    cycles(4);
    div_clk = 1'b1;
    cycles(6);
    check("div_rise_ticks", pins_out, 8'h5A);

    // random phase
    div_auto = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) div_half = $urandom_range(1, 4);
      if ($urandom_range(0, 99) == 0) stable_cycles = CW'($urandom_range(0, 5));
      if ($urandom_range(0, 63) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, W - 1);
        pins_in[idx] = ~pins_in[idx];
      end
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    en = 1'b1;
    cycles(50);
    check("expected_queue_drained", exp_q.size(), 0);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_debounce.md
GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of GPIO input pins.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 4, giving the width of each stability counter and of stable_cycles.
REQ-003 The block SHALL have parameter RESET_VAL, a WIDTH-bit value defaulting to all zeros, giving the reset value of pins_out.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all flops sit in this domain.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port div_clk, input, 1 bit: the divided-clock level from the GPIO clock divider, treated as asynchronous data and never used as a clock.
REQ-007 The block SHALL have port pins_in, input, WIDTH bits: raw asynchronous pad inputs.
REQ-008 The block SHALL have port en, input, 1 bit: debounce enable.
REQ-009 The block SHALL have port stable_cycles, input, CNT_WIDTH bits: the number of consecutive differing samples required before a pin change is accepted.
REQ-010 The block SHALL have port pins_out, output, WIDTH bits: the debounced pin levels.
REQ-011 The block SHALL have port rise, output, WIDTH bits: a one-clk pulse per pin on an accepted 0->1 change.
REQ-012 The block SHALL have port fall, output, WIDTH bits: a one-clk pulse per pin on an accepted 1->0 change.
REQ-013 The block SHALL have port changed, output, 1 bit: the OR of rise and fall.

Function
REQ-014 The block SHALL pass pins_in and div_clk each through a two-flop synchronizer before any use.
REQ-015 The block SHALL register the synchronized div_clk once more (div_q).
REQ-016 The block SHALL generate tick = sync_div & ~div_q, giving one clk-wide tick per div_clk rising edge.
REQ-017 Per pin i, on a clk edge with tick=1 and en=1: if sync_pin[i]==pins_out[i], count[i] SHALL clear to 0.
REQ-018 Per pin i, on a clk edge with tick=1 and en=1: if sync_pin[i]!=pins_out[i] and count[i]+1 >= thr, pins_out[i] SHALL take sync_pin[i] and count[i] SHALL clear.
REQ-019 Per pin i, on a clk edge with tick=1 and en=1: if sync_pin[i]!=pins_out[i] and count[i]+1 < thr, count[i] SHALL increment by 1.
REQ-020 thr SHALL equal stable_cycles, except that stable_cycles=0 SHALL be treated as thr=1.
REQ-021 The comparison count+1 >= thr SHALL be computed at CNT_WIDTH+1 bits so it cannot wrap.
REQ-022 On clk edges with tick=0, counters and pins_out SHALL hold.
REQ-023 When en=0, counters SHALL clear every clk, pins_out SHALL hold, and rise, fall and changed SHALL stay 0.
REQ-024 rise[i] or fall[i] SHALL be registered and asserted for exactly the one clk cycle in which pins_out[i] first shows its new value.
REQ-025 Multiple pins changing on the same tick SHALL each pulse independently in the same cycle.
REQ-026 If stable_cycles is lowered below a pin's current count, that pin SHALL update on the next tick on which it still differs.
REQ-027 Latency SHALL be: a pin change held steady is visible on pins_out at the thr-th tick edge occurring at least 2 clk after the change; with a fast div_clk and thr=1 this is 3 clk minimum.
REQ-028 A pin that returns to its pins_out value before reaching thr SHALL produce no output change and no pulse.

Reset
REQ-029 While rst_n=0, pins_out SHALL equal RESET_VAL; rise, fall, changed, all counters, all synchronizer flops and div_q SHALL be 0.
REQ-030 Reset asserted mid-count SHALL discard partial counts with no pulse on release.
REQ-031 The first tick after reset release SHALL require a synchronized div_clk 0->1 transition; a div_clk already high at release SHALL NOT tick until it has gone low and high again.

Structure
REQ-032 Shared package gpio_pkg SHALL hold the GPIO_WIDTH default and the CNT_WIDTH default constants.
REQ-033 The two-flop synchronizer SHALL be the sub-module gpio_sync, parameterized by width and instanced once for pins_in and once for div_clk.
REQ-034 The per-pin counter logic SHALL be a generate loop, not a sub-module.

Verification
REQ-035 Scenario: stable_cycles=3, pin0 0->1 held steady -> pins_out[0]=1 on the 3rd tick, rise[0] high for 1 clk, changed=1 in the same cycle.
REQ-036 Scenario: stable_cycles=3, pin2 toggles 1 tick high then low (glitch) -> pins_out unchanged, no rise, fall or changed.
REQ-037 Scenario: stable_cycles=0, pins 0..7 all 0->1 together -> all update on the first qualifying tick, rise=8'hFF for 1 clk.
REQ-038 Scenario: en=0 while pin5 changes for 10 ticks, then en=1 -> no change during en=0, and pins_out[5] updates stable_cycles ticks after en rises.
REQ-039 Scenario: rst_n pulsed low at count=2 of 3 with RESET_VAL=8'hA5 -> pins_out=8'hA5 asynchronously, no pulse, and the count restarts from 0.
REQ-040 Scenario: div_clk held high across reset release -> no tick until div_clk falls then rises again.
